ps2_cmd_sequencer: RTL and testbench

Host-to-device command transmitter for the PS/2 keyboard port. It accepts one command byte over a valid/ready handshake, such as 8'hED (set LEDs), 8'hF4 (enable) or 8'hFF (reset). It then runs the PS/2 request-to-send sequence on the open-drain clock and data lines and checks the device's line-level acknowledge. It sits beside the scan-code receiver and drives `tx_active` so the receiver ignores line activity while a command is in flight.

---
 rtl/ps2_cmd_sequencer_if.sv | 19 +
 rtl/ps2_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_sequencer_if.sv
// Command handshake between a host controller and the PS/2 command sequencer.
// A byte transfers on any cycle where cmd_valid and cmd_ready are both high.
interface ps2_cmd_sequencer_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-edge frame and
// line-level acknowledge check, with a timeout covering the whole device-clocked phase.
module ps2_cmd_sequencer #(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000
) (
    input  logic                      clk,
    input  logic                      rst,
    ps2_cmd_sequencer_if.slave        cmd,
    input  logic                      ps2_clk_in,
    input  logic                      ps2_din,
    output logic                      ps2_clk_oe,
    output logic                      ps2_dat_oe,
    output logic                      tx_active,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int unsigned CntMax = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StInhibit, StRts, StShift, StAck} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [8:0]        frame_q, frame_d;
    logic              clk_oe_q, clk_oe_d;
    logic              dat_oe_q, dat_oe_d;
    logic              tx_active_q, tx_active_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic [3:0]        clk_hist_q;
    logic              fe;

    // History bit 3 is the oldest sample; two highs followed by two lows is a clean fall.
    assign fe = (clk_hist_q == 4'b1100);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    frame_d    = {~^cmd.cmd_data, cmd.cmd_data};
                    err_code_d = 2'b00;
                    cnt_d      = '0;
                    clk_oe_d   = 1'b1;
                    dat_oe_d   = 1'b0;
                    state_d    = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYC - 1)) begin
                    cnt_d    = '0;
                    idx_d    = 4'd0;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    state_d  = StRts;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRts, StShift, StAck: begin
                cnt_d = cnt_q + CntW'(1);
                // Expiry takes priority over a coincident falling edge.
                if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    clk_oe_d   = 1'b0;
                    dat_oe_d   = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = StIdle;
                end else if (fe) begin
                    if (state_q == StAck) begin
                        state_d = StIdle;
                        if (dat_sync_q) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (idx_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        idx_d    = idx_q + 4'd1;
                        state_d  = StAck;
                    end else begin
                        dat_oe_d = ~frame_q[idx_q];
                        idx_d    = idx_q + 4'd1;
                        state_d  = StShift;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        tx_active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= 4'd0;
            frame_q     <= 9'd0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            clk_hist_q  <= 4'b1111;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            clk_oe_q    <= clk_oe_d;
            dat_oe_q    <= dat_oe_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_din;
            dat_sync_q  <= dat_meta_q;
            clk_hist_q  <= {clk_hist_q[2:0], clk_sync_q};
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_dat_oe    = dat_oe_q;
    assign tx_active     = tx_active_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: a behavioural PS/2 device clocks frames out of the host and
// every captured frame and status pulse is compared with values derived from the command byte.
module tb_ps2_cmd_sequencer;

    localparam int unsigned Inhibit = 8;
    localparam int unsigned Timeout = 2000;
    localparam int DevAck    = 0;
    localparam int DevNoAck  = 1;
    localparam int DevSilent = 2;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk_in, ps2_din;
    logic       ps2_clk_oe, ps2_dat_oe, tx_active, done, err;
    logic [1:0] err_code;
    logic       dev_clk_low, dev_dat_low, dev_busy;
    int         dev_mode;
    logic [10:0] dev_frame;
    logic [10:0] frames_q[$];
    int         n_chk, n_err;
    int         done_cnt, err_cnt;

    ps2_cmd_sequencer_if cmd_if ();

    ps2_cmd_sequencer #(
        .INHIBIT_CYC(Inhibit),
        .TIMEOUT_CYC(Timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .cmd       (cmd_if),
        .ps2_clk_in(ps2_clk_in),
        .ps2_din   (ps2_din),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_active (tx_active),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // Open-drain lines: either side pulling low wins.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_din    = ~(ps2_dat_oe | dev_dat_low);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Frame as the device sees it: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    // Device: on request-to-send, generate 11 clocks of 40 cycles and sample on rising edges.
    initial begin
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_busy    = 1'b0;
        dev_frame   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && !ps2_clk_oe && ps2_dat_oe && dev_mode != DevSilent) begin
                dev_busy = 1'b1;
                repeat (10) @(negedge clk);
                dev_frame    = '0;
                dev_frame[0] = ps2_din;
                for (int n = 1; n <= 11; n++) begin
                    if (n == 11 && dev_mode == DevAck) dev_dat_low = 1'b1;
                    dev_clk_low = 1'b1;
                    repeat (20) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (n <= 10) dev_frame[n] = ps2_din;
                    dev_dat_low = 1'b0;
                    repeat (20) @(negedge clk);
                end
                frames_q.push_back(dev_frame);
                dev_busy = 1'b0;
            end
        end
    end

    task automatic start_cmd(input logic [7:0] b, input bit hold_ff);
        @(negedge clk);
        check_eq("ready_before_accept", int'(cmd_if.cmd_ready), 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = b;
        @(negedge clk);
        if (hold_ff) cmd_if.cmd_data = 8'hFF;
        else cmd_if.cmd_valid = 1'b0;
    endtask

    // Entered at the negedge of the first cycle after acceptance.
    task automatic check_inhibit();
        int n = 0;
        check_eq("busy_ready", int'(cmd_if.cmd_ready), 0);
        check_eq("busy_tx_active", int'(tx_active), 1);
        while (ps2_clk_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("inhibit_len", n, Inhibit);
        check_eq("rts_dat_oe", int'(ps2_dat_oe), 1);
    endtask

    task automatic wait_result(input int bound, output int cycles);
        cycles = 0;
        while (!(done || err) && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        check_eq("result_seen", int'(done | err), 1);
    endtask

    task automatic wait_dev_idle();
        int n = 0;
        while (dev_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("device_idle", int'(dev_busy), 0);
    endtask

    task automatic check_frame(input logic [7:0] b);
        wait_dev_idle();
        check_eq("frame_available", int'(frames_q.size() != 0), 1);
        if (frames_q.size() != 0) check_eq("frame_bits", int'(frames_q.pop_front()),
                                           int'(model_frame(b)));
    endtask

    task automatic do_cmd(input logic [7:0] b, input int mode);
        int cyc;
        int d0, e0;
        dev_mode = mode;
        d0 = done_cnt;
        e0 = err_cnt;
        start_cmd(b, 1'b0);
        check_inhibit();
        wait_result(2500, cyc);
        if (mode == DevAck) begin
            check_eq("done_pulse", int'(done), 1);
            check_eq("ack_err_code", int'(err_code), 0);
        end else if (mode == DevNoAck) begin
            check_eq("noack_err", int'(err), 1);
            check_eq("noack_err_code", int'(err_code), 1);
            check_eq("noack_ready", int'(cmd_if.cmd_ready), 1);
            check_eq("noack_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        end else begin
            check_eq("timeout_cycles", cyc, Timeout);
            check_eq("timeout_err", int'(err), 1);
            check_eq("timeout_err_code", int'(err_code), 2);
            check_eq("timeout_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        end
        @(negedge clk);
        check_eq("pulse_single_cycle", int'(done | err), 0);
        if (mode != DevSilent) check_frame(b);
        else repeat (5) @(negedge clk);
        #1;
        check_eq("done_count", done_cnt - d0, (mode == DevAck) ? 1 : 0);
        check_eq("err_count", err_cnt - e0, (mode == DevAck) ? 0 : 1);
        dev_mode = DevAck;
    endtask

    initial begin
        int cyc;
        int d0, e0;
        n_chk = 0;
        n_err = 0;
        done_cnt = 0;
        err_cnt = 0;
        dev_mode = DevAck;
        rst_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_clk_oe", int'(ps2_clk_oe), 0);
        check_eq("rst_dat_oe", int'(ps2_dat_oe), 0);
        check_eq("rst_tx_active", int'(tx_active), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_err_code", int'(err_code), 0);
        check_eq("rst_ready", int'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_cmd(8'hED, DevAck);
        do_cmd(8'hF4, DevAck);
        do_cmd(8'h00, DevAck);
        repeat (4) do_cmd(8'($urandom_range(0, 255)), DevAck);
        do_cmd(8'h5A, DevNoAck);
        do_cmd(8'h3C, DevSilent);
        // A successful command after an error clears err_code.
        do_cmd(8'($urandom_range(0, 255)), DevAck);

        // Busy: 8'hFF offered throughout the transfer must not be captured.
        d0 = done_cnt;
        start_cmd(8'hA7, 1'b1);
        check_inhibit();
        repeat (300) @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        wait_result(600, cyc);
        check_eq("busy_done", int'(done), 1);
        check_frame(8'hA7);
        #1;
        check_eq("busy_done_count", done_cnt - d0, 1);
        check_eq("busy_idle_after", int'(tx_active), 0);

        // Reset during the shift phase releases both lines without a status pulse.
        d0 = done_cnt;
        e0 = err_cnt;
        start_cmd(8'hC3, 1'b0);
        check_inhibit();
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        check_eq("async_rst_ready", int'(cmd_if.cmd_ready), 1);
        check_eq("async_rst_tx_active", int'(tx_active), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_dev_idle();
        frames_q.delete();
        repeat (10) @(negedge clk);
        #1;
        check_eq("rst_no_done", done_cnt - d0, 0);
        check_eq("rst_no_err", err_cnt - e0, 0);
        check_eq("rst_idle_ready", int'(cmd_if.cmd_ready), 1);

        // Back-to-back: second byte accepted in the done cycle.
        d0 = done_cnt;
        start_cmd(8'h81, 1'b0);
        check_inhibit();
        repeat (300) @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 8'h6E;
        wait_result(600, cyc);
        check_eq("b2b_first_done", int'(done), 1);
        check_eq("b2b_ready_in_done", int'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_eq("b2b_inhibit_restart", int'(ps2_clk_oe), 1);
        check_inhibit();
        wait_result(2500, cyc);
        check_eq("b2b_second_done", int'(done), 1);
        check_frame(8'h81);
        check_frame(8'h6E);
        #1;
        check_eq("b2b_done_count", done_cnt - d0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
